// File: rtl/clk_freq_meter_pkg.sv
//------------------------------------------------------------------------------
// clk_freq_meter_pkg : FSM state encoding and gate-counter sizing helper.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package clk_freq_meter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GATE = 1'b1
    } state_e;

    // Width of a counter that runs 0 .. gate_cycles-1.
    function automatic int gate_cnt_width(input int gate_cycles);
        return (gate_cycles < 2) ? 1 : $clog2(gate_cycles);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
//------------------------------------------------------------------------------
// sync_edge_det : 2-flop synchroniser plus edge register, rising-edge output.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic edge_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    // Edge flags in the cycle the third stage is loading a 1 over a 0.
    assign rise_o = sync2_q & ~edge_q;

endmodule

`default_nettype wire

// File: rtl/clk_freq_meter.sv
//------------------------------------------------------------------------------
// clk_freq_meter : gated edge counter with range check and debounced lock.
// Optional: CLK_FREQ_METER_UNLOCK_HYST_EN adds two-bad-window unlock hysteresis.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clk_freq_meter
    import clk_freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES  = 24000,
    parameter int CNT_W        = 16,
    parameter int EXP_MIN      = 990,
    parameter int EXP_MAX      = 1010,
    parameter int LOCK_WINDOWS = 4
) (
    input  logic             clki_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             meas_in_i,
    output logic [CNT_W-1:0] count_o,
    output logic             count_valid_o,
    output logic             in_range_o,
    output logic             overflow_o,
    output logic             locked_o
);

    localparam int GW = gate_cnt_width(GATE_CYCLES);
    localparam int LW = $clog2(LOCK_WINDOWS + 1);

    localparam logic [GW-1:0]    C_GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_EXP_MIN   = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0] C_EXP_MAX   = CNT_W'(EXP_MAX);
    localparam logic [LW-1:0]    C_LOCK_N    = LW'(LOCK_WINDOWS);

    logic w_rise;

    sync_edge_det u_sync (
        .clk_i  (clki_i),
        .rst_i  (rst_i),
        .d_i    (meas_in_i),
        .rise_o (w_rise)
    );

    state_e           state_q;
    logic [GW-1:0]    gate_cnt_q;
    logic [CNT_W-1:0] edge_cnt_q;
    logic             win_ovf_q;
    logic [CNT_W-1:0] count_q;
    logic             valid_q;
    logic             in_range_q;
    logic             overflow_q;
    logic [LW-1:0]    good_cnt_q;
    logic             locked_q;
`ifdef CLK_FREQ_METER_UNLOCK_HYST_EN
    logic             bad_prev_q;
`endif

    logic [CNT_W-1:0] edge_cnt_d;
    logic             win_ovf_d;
    logic             w_sat;
    logic             w_last;
    logic             w_in_range;
    logic [LW-1:0]    good_cnt_d;

    always_comb begin
        w_sat      = &edge_cnt_q;
        edge_cnt_d = (w_rise && !w_sat) ? edge_cnt_q + 1'b1 : edge_cnt_q;
        win_ovf_d  = win_ovf_q | (w_rise & w_sat);
        w_last     = (gate_cnt_q == C_GATE_LAST);
        w_in_range = !win_ovf_d && (edge_cnt_d >= C_EXP_MIN) && (edge_cnt_d <= C_EXP_MAX);
        good_cnt_d = (good_cnt_q == C_LOCK_N) ? good_cnt_q : good_cnt_q + 1'b1;
    end

    always_ff @(posedge clki_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            win_ovf_q  <= 1'b0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            in_range_q <= 1'b0;
            overflow_q <= 1'b0;
            good_cnt_q <= '0;
            locked_q   <= 1'b0;
`ifdef CLK_FREQ_METER_UNLOCK_HYST_EN
            bad_prev_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    gate_cnt_q <= '0;
                    edge_cnt_q <= '0;
                    win_ovf_q  <= 1'b0;
                    good_cnt_q <= '0;
                    locked_q   <= 1'b0;
`ifdef CLK_FREQ_METER_UNLOCK_HYST_EN
                    bad_prev_q <= 1'b0;
`endif
                    if (enable_i) begin
                        state_q <= ST_GATE;
                    end
                end
                ST_GATE: begin
                    if (!enable_i) begin
                        // Partial window is dropped; result registers keep their values.
                        state_q    <= ST_IDLE;
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                        win_ovf_q  <= 1'b0;
                        good_cnt_q <= '0;
                        locked_q   <= 1'b0;
`ifdef CLK_FREQ_METER_UNLOCK_HYST_EN
                        bad_prev_q <= 1'b0;
`endif
                    end else if (w_last) begin
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                        win_ovf_q  <= 1'b0;
                        count_q    <= edge_cnt_d;
                        overflow_q <= win_ovf_d;
                        in_range_q <= w_in_range;
                        valid_q    <= 1'b1;
                        if (w_in_range) begin
                            good_cnt_q <= good_cnt_d;
                            if (good_cnt_d == C_LOCK_N) begin
                                locked_q <= 1'b1;
                            end
`ifdef CLK_FREQ_METER_UNLOCK_HYST_EN
                            bad_prev_q <= 1'b0;
`endif
                        end else begin
                            good_cnt_q <= '0;
`ifdef CLK_FREQ_METER_UNLOCK_HYST_EN
                            bad_prev_q <= 1'b1;
                            if (win_ovf_d || bad_prev_q) begin
                                locked_q <= 1'b0;
                            end
`else
                            locked_q <= 1'b0;
`endif
                        end
                    end else begin
                        gate_cnt_q <= gate_cnt_q + 1'b1;
                        edge_cnt_q <= edge_cnt_d;
                        win_ovf_q  <= win_ovf_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign count_o       = count_q;
    assign count_valid_o = valid_q;
    assign in_range_o    = in_range_q;
    assign overflow_o    = overflow_q;
    assign locked_o      = locked_q;

endmodule

`default_nettype wire
